// File: rtl/mem_lsu.sv
// Memory-stage load/store unit. Turns one M-stage load or store into a single
// word-aligned bus transaction with byte enables, stalls the pipeline until the
// bus completes, and returns aligned, sign- or zero-extended load data.
module mem_lsu (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AccessFaultM
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        access;
  logic        legal_f3;
  logic        misaligned;
  logic        legal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_fmt;

  // RegWriteM does not influence the LSU; it is only carried on the port list.
  logic unused_regwrite;
  assign unused_regwrite = RegWriteM;

  // Decode the M-stage instruction: access type, legality and bus encoding.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    access     = MemWriteM | (ResultSrcM == 2'b01);
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = 32'h0;

    case (funct3M)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = ~MemWriteM;  // unsigned forms are load-only
      default:                legal_f3 = 1'b0;
    endcase

    case (funct3M[1:0])
      2'b01:   misaligned = ALUResultM[0];
      2'b10:   misaligned = |ALUResultM[1:0];
      default: misaligned = 1'b0;
    endcase

    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          be_d    = 4'b0001 << ALUResultM[1:0];
          wdata_d = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{WriteDataM[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = WriteDataM;
        end
      endcase
    end

    legal = legal_f3 & ~misaligned;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is assigned with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one request per access, one DONE cycle to release the pipe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && legal) state_d = REQ;
      REQ:     if (mem_ready)       state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the bus transaction when a legal access is accepted in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'h0;
      funct3_q  <= 3'b0;
      off_q     <= 2'b0;
    end else if (state_q == IDLE && access && legal) begin
      mem_we    <= MemWriteM;
      mem_addr  <= {ALUResultM[31:2], 2'b00};
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
      funct3_q  <= funct3M;
      off_q     <= ALUResultM[1:0];
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_fmt = {24'h0, rd_byte};
      3'b101:  rd_fmt = {16'h0, rd_half};
      default: rd_fmt = mem_rdata;
    endcase
  end

  // Load result register: updated only when a load completes on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    ReadDataM <= 32'h0;
    else if (state_q == REQ && mem_ready && !mem_we) ReadDataM <= rd_fmt;
  end

  // Handshake and pipeline control. Stall and fault are qualified by reset so
  // the pipeline is never held, nor a fault raised, while the unit is in reset.
  always_comb begin
    mem_req      = (state_q == REQ);
    StallM       = reset & (((state_q == IDLE) & access & legal) | (state_q == REQ));
    AccessFaultM = reset & (state_q == IDLE) & access & ~legal;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed accesses against a transaction-level
// model that derives expected bus and pipeline behaviour from the access rules.
`timescale 1ns/1ps
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic        RegWriteM = 1'b0;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [2:0]  funct3M = 3'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] ReadDataM;
  logic        StallM, AccessFaultM;

  mem_lsu dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RegWriteM(RegWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .funct3M(funct3M), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .ReadDataM(ReadDataM), .StallM(StallM),
    .AccessFaultM(AccessFaultM)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state (what the outputs must be this cycle) -------
  logic        m_stall = 1'b0, m_fault = 1'b0, m_req = 1'b0;
  logic        m_bus = 1'b1, m_chk_wdata = 1'b1, m_we = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;
  logic [3:0]  m_be = 4'h0;

  // Observation counters, only ever written by the compare process.
  int stall_seen = 0, req_seen = 0, fault_seen = 0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic        last_we = 1'b0;

  // Access legality from the instruction-set rules: size 2^f3[1:0] bytes,
  // unsigned variants only for loads smaller than a word, natural alignment.
  function automatic logic legal_access(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size = int'(f3[1:0]);
    if (size == 3) return 1'b0;
    if (f3[2] && (we || size == 2)) return 1'b0;
    return (int'(a[1:0]) % (1 << size)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int nbytes = 1 << int'(f3[1:0]);
    int mask = ((1 << nbytes) - 1) << int'(a[1:0]);
    if (!we) return 4'hF;
    return mask[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int nbytes = 1 << int'(f3[1:0]);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * int'(a[1:0]));
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return rd;
    endcase
  endfunction

  // ---------------- compare process (every falling edge) --------------------
  always @(negedge clk) begin
    check("StallM", {31'h0, StallM}, {31'h0, m_stall});
    check("AccessFaultM", {31'h0, AccessFaultM}, {31'h0, m_fault});
    check("mem_req", {31'h0, mem_req}, {31'h0, m_req});
    check("ReadDataM", ReadDataM, m_rdata);
    if (m_bus) begin
      check("mem_we", {31'h0, mem_we}, {31'h0, m_we});
      check("mem_addr", mem_addr, m_addr);
      check("mem_be", {28'h0, mem_be}, {28'h0, m_be});
    end
    if (m_chk_wdata) check("mem_wdata", mem_wdata, m_wdata);
    if (StallM) stall_seen++;
    if (AccessFaultM) fault_seen++;
    if (mem_req) begin
      req_seen++;
      last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_idle();
    m_stall = 1'b0; m_fault = 1'b0; m_req = 1'b0; m_bus = 1'b0; m_chk_wdata = 1'b0;
  endtask

  task automatic drive_idle();
    MemWriteM = 1'b0; ResultSrcM = 2'b00; mem_ready = 1'b0;
    model_idle();
  endtask

  // Present one instruction in M and walk it through its whole M-stage life.
  task automatic do_access(input logic we, input logic [1:0] rs, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input int waits, input logic [31:0] rd);
    logic acc, ok;
    acc = we || (rs == 2'b01);
    ok  = acc && legal_access(we, f3, a);
    MemWriteM = we; ResultSrcM = rs; ALUResultM = a; WriteDataM = wd; funct3M = f3;
    RegWriteM = ~we;
    mem_ready = 1'b1;          // must be ignored outside REQ
    mem_rdata = ~rd;
    model_idle();
    m_stall = ok; m_fault = acc && !ok;
    tick();
    if (ok) begin
      for (int k = 0; k <= waits; k++) begin
        mem_ready = (k == waits);
        mem_rdata = (k == waits) ? rd : ~rd;
        m_req = 1'b1; m_stall = 1'b1; m_fault = 1'b0; m_bus = 1'b1;
        m_we = we; m_addr = {a[31:2], 2'b00}; m_be = model_be(we, f3, a);
        m_chk_wdata = we; m_wdata = model_wdata(f3, wd);
        tick();
      end
      if (!we) m_rdata = model_load(f3, a, rd);
      model_idle();
      mem_ready = 1'b1;        // DONE ignores the bus
      mem_rdata = 32'h0;
      tick();
    end
    drive_idle();
  endtask

  int s0, r0, f0;
  task automatic snap();
    s0 = stall_seen; r0 = req_seen; f0 = fault_seen;
  endtask

  initial begin
    // Reset held while a legal LW is on the inputs: everything stays quiet.
    MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h100;
    m_bus = 1'b1; m_chk_wdata = 1'b1;
    repeat (3) tick();
    check("rst mem_req", {31'h0, mem_req}, 32'h0);
    check("rst StallM", {31'h0, StallM}, 32'h0);
    check("rst ReadDataM", ReadDataM, 32'h0);
    drive_idle();
    tick();
    reset = 1'b1;
    tick();

    // Non-access instruction: one cycle, no stall.
    snap();
    do_access(1'b0, 2'b10, 32'h1000, 32'h0, 3'b010, 0, 32'h0);
    check("nonacc stall cnt", stall_seen - s0, 0);

    // LB at 0x1003, zero wait.
    snap();
    do_access(1'b0, 2'b01, 32'h1003, 32'h0, 3'b000, 0, 32'h80AA_BBCC);
    check("LB data", ReadDataM, 32'hFFFF_FF80);
    check("LB stall cnt", stall_seen - s0, 2);
    check("LB req cnt", req_seen - r0, 1);
    check("LB addr", last_addr, 32'h1000);
    check("LB be", {28'h0, last_be}, 32'hF);

    do_access(1'b0, 2'b01, 32'h1003, 32'h0, 3'b100, 0, 32'h80AA_BBCC);
    check("LBU data", ReadDataM, 32'h0000_0080);

    // SH at 0x2002.
    do_access(1'b1, 2'b00, 32'h2002, 32'h1234_ABCD, 3'b001, 0, 32'h0);
    check("SH we", {31'h0, last_we}, 32'h1);
    check("SH be", {28'h0, last_be}, 32'hC);
    check("SH wdata", last_wdata, 32'hABCD_ABCD);
    check("SH keeps ReadDataM", ReadDataM, 32'h0000_0080);

    // LW with four wait states.
    snap();
    do_access(1'b0, 2'b01, 32'h4000, 32'h0, 3'b010, 4, 32'hDEAD_BEEF);
    check("LW wait stall cnt", stall_seen - s0, 6);
    check("LW wait req cnt", req_seen - r0, 5);
    check("LW wait data", ReadDataM, 32'hDEAD_BEEF);

    // Faults: misaligned LW, reserved funct3 load, unsigned-form store.
    snap();
    do_access(1'b0, 2'b01, 32'h3001, 32'h0, 3'b010, 0, 32'h0);
    do_access(1'b0, 2'b01, 32'h3000, 32'h0, 3'b011, 0, 32'h0);
    do_access(1'b1, 2'b00, 32'h3000, 32'h5, 3'b100, 0, 32'h0);
    check("fault cnt", fault_seen - f0, 3);
    check("fault req cnt", req_seen - r0, 0);
    check("fault stall cnt", stall_seen - s0, 0);

    // More formatting and encoding cases.
    do_access(1'b0, 2'b01, 32'h1002, 32'h0, 3'b001, 1, 32'h80AA_BBCC);
    check("LH data", ReadDataM, 32'hFFFF_80AA);
    do_access(1'b0, 2'b01, 32'h1000, 32'h0, 3'b101, 0, 32'h80AA_BBCC);
    check("LHU data", ReadDataM, 32'h0000_BBCC);
    do_access(1'b0, 2'b01, 32'h1001, 32'h0, 3'b000, 2, 32'h80AA_BBCC);
    check("LB1 data", ReadDataM, 32'hFFFF_FFBB);
    do_access(1'b1, 2'b01, 32'h5001, 32'h0000_00EF, 3'b000, 0, 32'h0);
    check("SB be", {28'h0, last_be}, 32'h2);
    check("SB wdata", last_wdata, 32'hEFEF_EFEF);
    check("SB keeps ReadDataM", ReadDataM, 32'hFFFF_FFBB);
    do_access(1'b1, 2'b00, 32'h6000, 32'h0BAD_CAFE, 3'b010, 1, 32'h0);
    check("SW wdata", last_wdata, 32'h0BAD_CAFE);

    // Reset pulsed during the REQ of a store.
    MemWriteM = 1'b1; ResultSrcM = 2'b00; ALUResultM = 32'h6004;
    WriteDataM = 32'hCAFE_F00D; funct3M = 3'b010; mem_ready = 1'b0;
    model_idle(); m_stall = 1'b1;
    tick();
    m_req = 1'b1; m_stall = 1'b1; m_bus = 1'b1; m_chk_wdata = 1'b1;
    m_we = 1'b1; m_addr = 32'h6004; m_be = 4'hF; m_wdata = 32'hCAFE_F00D;
    #2;
    check("pre-rst mem_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b0;
    m_req = 1'b0; m_stall = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_be = 4'h0;
    m_wdata = 32'h0; m_rdata = 32'h0;
    #1;
    check("midrst mem_req", {31'h0, mem_req}, 32'h0);
    check("midrst mem_we", {31'h0, mem_we}, 32'h0);
    check("midrst mem_addr", mem_addr, 32'h0);
    check("midrst mem_be", {28'h0, mem_be}, 32'h0);
    check("midrst mem_wdata", mem_wdata, 32'h0);
    check("midrst StallM", {31'h0, StallM}, 32'h0);
    check("midrst ReadDataM", ReadDataM, 32'h0);
    tick();
    MemWriteM = 1'b0;
    tick();
    reset = 1'b1;
    model_idle();
    tick();

    // Unit recovers and serves a fresh load.
    do_access(1'b0, 2'b01, 32'h7008, 32'h0, 3'b010, 0, 32'h1357_9BDF);
    check("post-rst LW", ReadDataM, 32'h1357_9BDF);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
